// File: rtl/inst_fetch_buffer.sv
// Instruction-fetch front end: sequential ROM reads, fixed read latency, small FIFO to decode.
// Optional misaligned-redirect fault entry under `FETCH_MISALIGN_FAULT_EN`.
module inst_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        rom_en,
  output logic [19:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          pipe_v_q  [ROM_LAT];
  logic          pipe_v_d  [ROM_LAT];
  logic [31:0]   pipe_pc_q [ROM_LAT];
  logic [31:0]   pipe_pc_d [ROM_LAT];

  logic [31:0]   mem_inst_q [DEPTH];
  logic [31:0]   mem_pc_q   [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   hold_inst_q, hold_pc_q;
  logic          hold_fault_q;

  logic [SW-1:0] inflight;
  logic [SW-1:0] occupancy;
  logic          halted;
  logic          issue;
  logic          ret_v;
  logic          wr_en;
  logic          pop;
  logic [31:0]   wr_inst;
  logic [31:0]   wr_pc;
  logic          wr_fault;
  logic [31:0]   head_inst;
  logic [31:0]   head_pc;
  logic          head_fault;

`ifdef FETCH_MISALIGN_FAULT_EN
  typedef enum logic [1:0] {
    FETCH_RUN,
    FETCH_FAULT,
    FETCH_HALT
  } fetch_state_e;

  fetch_state_e state_q, state_d;
  logic [31:0]  fault_pc_q, fault_pc_d;
  logic         mem_fault_q [DEPTH];
  logic         misaligned;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH_RUN;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  // FETCH_FAULT writes the synthetic NOP entry on its single cycle, then parks in FETCH_HALT.
  always_comb begin
    state_d    = state_q;
    fault_pc_d = fault_pc_q;
    misaligned = (redirect_pc[1:0] != 2'b00);
    if (redirect_valid) begin
      state_d    = misaligned ? FETCH_FAULT : FETCH_RUN;
      fault_pc_d = redirect_pc;
    end else if (state_q == FETCH_FAULT) begin
      state_d = FETCH_HALT;
    end
  end

  always_comb begin
    halted   = (state_q != FETCH_RUN);
    wr_fault = (state_q == FETCH_FAULT);
    wr_inst  = wr_fault ? 32'h0000_0013 : rom_data;
    wr_pc    = wr_fault ? fault_pc_q : pipe_pc_q[ROM_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_fault_q[wr_ptr_q] <= wr_fault;
  end

  assign head_fault = mem_fault_q[rd_ptr_q];
`else
  always_comb begin
    halted   = 1'b0;
    wr_fault = 1'b0;
    wr_inst  = rom_data;
    wr_pc    = pipe_pc_q[ROM_LAT-1];
  end

  assign head_fault = 1'b0;
`endif

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < ROM_LAT; i++) begin
      inflight = inflight + SW'(pipe_v_q[i]);
    end
    occupancy = SW'(count_q) + inflight;
    // Occupancy counts the returning stage and ignores same-cycle pops, so a write always has room.
    issue = rst_n && !redirect_valid && !halted && (occupancy < SW'(DEPTH));
    ret_v = pipe_v_q[ROM_LAT-1];
    wr_en = !redirect_valid && (ret_v || wr_fault);
    pop   = !redirect_valid && inst_valid && inst_ready;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    for (int unsigned i = 0; i < ROM_LAT; i++) begin
      pipe_v_d[i]  = 1'b0;
      pipe_pc_d[i] = pipe_pc_q[i];
    end
    if (redirect_valid) begin
`ifdef FETCH_MISALIGN_FAULT_EN
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
`else
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
`endif
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
      pipe_v_d[0]  = issue;
      pipe_pc_d[0] = fetch_pc_q;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        pipe_v_d[i]  = pipe_v_q[i-1];
        pipe_pc_d[i] = pipe_pc_q[i-1];
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(wr_en) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < ROM_LAT; i++) pipe_v_q[i] <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int unsigned i = 0; i < ROM_LAT; i++) pipe_v_q[i] <= pipe_v_d[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < ROM_LAT; i++) pipe_pc_q[i] <= pipe_pc_d[i];
    if (wr_en) begin
      mem_inst_q[wr_ptr_q] <= wr_inst;
      mem_pc_q[wr_ptr_q]   <= wr_pc;
    end
  end

  assign head_inst = mem_inst_q[rd_ptr_q];
  assign head_pc   = mem_pc_q[rd_ptr_q];

  // Shadow of the current head so the outputs keep the last head value once the FIFO drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_inst_q  <= '0;
      hold_pc_q    <= '0;
      hold_fault_q <= 1'b0;
    end else if (count_q != '0) begin
      hold_inst_q  <= head_inst;
      hold_pc_q    <= head_pc;
      hold_fault_q <= head_fault;
    end
  end

  always_comb begin
    rom_en     = issue;
    rom_addr   = fetch_pc_q[21:2];
    inst_valid = (count_q != '0);
    inst       = inst_valid ? head_inst  : hold_inst_q;
    inst_pc    = inst_valid ? head_pc    : hold_pc_q;
    inst_fault = inst_valid ? head_fault : hold_fault_q;
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Scoreboard bench for inst_fetch_buffer: behavioural ROM, expected-entry queue refilled on reset/redirect.
module tb_inst_fetch_buffer;

  localparam int unsigned LAT = 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        flt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        rom_en;
  logic [19:0] rom_addr;
  logic [31:0] rom_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  logic [31:0] rom_sr [LAT];
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  inst_fetch_buffer #(
    .RESET_PC (32'h0000_0000),
    .ROM_LAT  (LAT),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_en         (rom_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  // ROM word k holds 0x1000_0000 + k; idle cycles return a poison word.
  always @(posedge clk) begin
    rom_sr[0] <= rom_en ? (32'h1000_0000 + {12'h000, rom_addr}) : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) rom_sr[i] <= rom_sr[i-1];
  end
  assign rom_data = rom_sr[LAT-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h1000_0000 + {12'h000, pc[21:2]};
  endfunction

  task automatic push_seq(input logic [31:0] pc0, input int n);
    logic [31:0] p;
    exp_t e;
    p = pc0;
    for (int i = 0; i < n; i++) begin
      e.pc  = p;
      e.ins = rom_word(p);
      e.flt = 1'b0;
      sb.push_back(e);
      p = p + 32'd4;
    end
  endtask

  // Accepted-head monitor: a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && !redirect_valid && inst_valid && inst_ready) begin
      exp_t e;
      check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("head_pc", inst_pc, e.pc);
        check_eq("head_inst", inst, e.ins);
        check_eq("head_fault", {31'd0, inst_fault}, {31'd0, e.flt});
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) next_cycle();
  endtask

  // Cycles from the current one until inst_valid is first seen; -1 on timeout.
  task automatic measure_valid(input string tag, input int start, input int exp);
    int lat;
    bit seen;
    lat  = start;
    seen = 1'b0;
    for (int k = 0; k < 32 && !seen; k++) begin
      @(negedge clk);
      if (inst_valid) seen = 1'b1;
      else lat++;
    end
    check_eq(tag, seen ? 32'(lat) : 32'hFFFF_FFFF, 32'(exp));
    next_cycle();
  endtask

  task automatic release_reset();
    sb.delete();
    push_seq(32'h0000_0000, 64);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("issue_cycle0", {31'd0, rom_en}, 32'd1);
    check_eq("addr_cycle0", {12'd0, rom_addr}, 32'd0);
    next_cycle();
    measure_valid("reset_lat", 1, LAT + 1);
  endtask

  task automatic do_redirect(input logic [31:0] pc, input bit fault_entry, input bit busy);
    exp_t e;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    sb.delete();
    if (fault_entry) begin
      e.pc  = pc;
      e.ins = 32'h0000_0013;
      e.flt = 1'b1;
      sb.push_back(e);
    end else begin
      push_seq(pc & 32'hFFFF_FFFC, 64);
    end
    @(negedge clk);
    check_eq("redir_no_issue", {31'd0, rom_en}, 32'd0);
    if (busy) check_eq("redir_head_busy", {31'd0, inst_valid}, 32'd1);
    next_cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    run(3);
    @(negedge clk);
    check_eq("rst_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("rst_rom_en", {31'd0, rom_en}, 32'd0);
    check_eq("rst_inst", inst, 32'd0);
    check_eq("rst_inst_pc", inst_pc, 32'd0);
    check_eq("rst_fault", {31'd0, inst_fault}, 32'd0);
    next_cycle();

    release_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("no_gap", {31'd0, inst_valid}, 32'd1);
      next_cycle();
    end

    // Stall long enough for the FIFO to fill and issue to stop.
    inst_ready = 1'b0;
    run(9);
    @(negedge clk);
    check_eq("stall_no_issue", {31'd0, rom_en}, 32'd0);
    check_eq("stall_valid", {31'd0, inst_valid}, 32'd1);
    next_cycle();
    inst_ready = 1'b1;
    run(10);

    // Redirect while returns and pops are happening every cycle.
    do_redirect(32'h0000_0100, 1'b0, 1'b1);
    measure_valid("redir_lat", 1, LAT + 2);
    run(6);

    // Back-to-back redirects: only the second target may emerge.
    do_redirect(32'h0000_0300, 1'b0, 1'b1);
    do_redirect(32'h0000_0400, 1'b0, 1'b0);
    measure_valid("b2b_lat", 1, LAT + 2);
    run(5);

    // Address wrap at the top of the 32-bit space.
    do_redirect(32'hFFFF_FFFC, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("wrap_addr0", {12'd0, rom_addr}, 32'h000F_FFFF);
    check_eq("wrap_en0", {31'd0, rom_en}, 32'd1);
    next_cycle();
    @(negedge clk);
    check_eq("wrap_addr1", {12'd0, rom_addr}, 32'd0);
    next_cycle();
    run(6);

    // Reset in the middle of running fetch.
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_rom_en", {31'd0, rom_en}, 32'd0);
    next_cycle();
    check_eq("midrst_valid", {31'd0, inst_valid}, 32'd0);
    release_reset();
    run(4);

`ifdef FETCH_MISALIGN_FAULT_EN
    begin
      bit any_en;
      do_redirect(32'h0000_0102, 1'b1, 1'b1);
      measure_valid("fault_lat", 1, 2);
      any_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        any_en = any_en | rom_en;
        next_cycle();
      end
      check_eq("halt_no_issue", {31'd0, any_en}, 32'd0);
      check_eq("fault_single", 32'(sb.size()), 32'd0);
      check_eq("fault_drained", {31'd0, inst_valid}, 32'd0);
      check_eq("fault_hold_pc", inst_pc, 32'h0000_0102);
      do_redirect(32'h0000_0200, 1'b0, 1'b0);
      measure_valid("resume_lat", 1, LAT + 2);
      run(6);
    end
`else
    do_redirect(32'h0000_0102, 1'b0, 1'b1);
    measure_valid("misalign_lat", 1, LAT + 2);
    run(6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

endmodule
